// File: rtl/imem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_arbiter_pkg
// Shared definitions for the instruction-memory subsystem: the boot/run state
// encoding, default RAM geometry and the width of the loader starvation
// counter. The instruction memory and fetch stage reuse these.
// -----------------------------------------------------------------------------
package imem_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int STARVE_W   = 4;

    // Saturating increment of the starvation counter, clamped at lim.
    function automatic logic [STARVE_W-1:0] starve_inc(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] lim
    );
        if (cnt >= lim) begin
            return lim;
        end else begin
            return cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the fetch, loader, control and RAM-side signals of the instruction
// RAM arbiter.
//   slave  : the arbiter's view (fetch/load requests and mem_rdata in,
//            grants, fetched data, boot_done and RAM port out)
//   master : the surrounding system (CPU, loader and RAM)
// -----------------------------------------------------------------------------
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // fetch side
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    // loader side
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    // control
    logic              reboot;
    logic              boot_done;
    // RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, load_valid, load_addr, load_data,
               load_last, reboot, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_data, load_ready, boot_done,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, load_valid, load_addr, load_data,
               load_last, reboot, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_data, load_ready, boot_done,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Sequencer/arbiter for a single-port instruction RAM with 1-cycle synchronous
// read. After reset (BOOT) only the loader may use the RAM; the final loader
// word moves the block to RUN, where CPU fetches win unless a pending loader
// write has been refused STARVE_MAX cycles in a row, in which case the write
// is forced through for one cycle. reboot returns to BOOT.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : imem_arbiter_if.slave (fetch, loader, reboot/boot_done, RAM)
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    imem_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [STARVE_W-1:0] starve_cnt_nxt_s;
    logic                fetch_valid_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                fetch_gnt_s;
    logic                load_gnt_s;
    logic                load_ready_s;

    // State, starvation counter, read-in-flight flag and held RAM address/data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_BOOT;
            starve_cnt_r  <= {STARVE_W{1'b0}};
            fetch_valid_r <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            starve_cnt_r  <= starve_cnt_nxt_s;
            // A read granted now returns data next cycle, even across reboot.
            fetch_valid_r <= fetch_gnt_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
        end
    end

    // Arbitration, next state, starvation tracking and RAM port mux.
    always_comb begin
        state_nxt_s      = state_r;
        starve_cnt_nxt_s = {STARVE_W{1'b0}};
        fetch_gnt_s      = 1'b0;
        load_gnt_s       = 1'b0;
        load_ready_s     = 1'b1;
        mem_addr_s       = mem_addr_r;
        mem_wdata_s      = mem_wdata_r;

        case (state_r)
            ST_BOOT: begin
                // Loader owns the port; reboot in the same cycle as the last
                // word keeps us in BOOT.
                load_gnt_s = bus.load_valid;
                if (bus.load_valid && bus.load_last && !bus.reboot) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_BOOT;
                end
            end
            ST_RUN: begin
                // Fetch wins until the loader has been refused STARVE_MAX times.
                fetch_gnt_s  = bus.fetch_req && (starve_cnt_r < STARVE_LIM);
                load_ready_s = !fetch_gnt_s;
                load_gnt_s   = bus.load_valid && !fetch_gnt_s;
                if (bus.load_valid && !load_gnt_s) begin
                    starve_cnt_nxt_s = starve_inc(starve_cnt_r, STARVE_LIM);
                end else begin
                    starve_cnt_nxt_s = {STARVE_W{1'b0}};
                end
                if (bus.reboot) begin
                    state_nxt_s = ST_BOOT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase

        // Idle keeps the last address/data so the RAM inputs stay quiet.
        if (load_gnt_s) begin
            mem_addr_s  = bus.load_addr;
            mem_wdata_s = bus.load_data;
        end else if (fetch_gnt_s) begin
            mem_addr_s  = bus.fetch_addr;
            mem_wdata_s = mem_wdata_r;
        end else begin
            mem_addr_s  = mem_addr_r;
            mem_wdata_s = mem_wdata_r;
        end
    end

    assign bus.fetch_gnt   = fetch_gnt_s;
    assign bus.fetch_valid = fetch_valid_r;
    assign bus.fetch_data  = bus.mem_rdata;
    assign bus.load_ready  = load_ready_s;
    assign bus.boot_done   = (state_r == ST_RUN);
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_we      = load_gnt_s;
    assign bus.mem_wdata   = mem_wdata_s;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
// Self-checking bench for imem_arbiter: per-cycle vectors (inputs plus
// expected grant/ready/boot_done/RAM port) and a scoreboard that pushes the
// expected instruction word at each fetch grant and compares it when
// fetch_valid is due. A behavioural 1-cycle sync RAM sits on the RAM port.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    typedef struct {
        logic          fr;
        logic [AW-1:0] fa;
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          ll;
        logic          rb;
        logic          eg;   // expected fetch_gnt
        logic          er;   // expected load_ready
        logic          eb;   // expected boot_done
        logic          ew;   // expected mem_we
        logic [AW-1:0] ea;   // expected mem_addr
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural single-port RAM, 1-cycle synchronous read
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: bench-side memory image and expected read data queue
    logic [DW-1:0] model [0:(1<<AW)-1];
    logic [DW-1:0] sb_q [$];
    logic          exp_valid = 1'b0;
    logic          mon_en    = 1'b0;

    always @(negedge clock) begin
        if (mon_en) begin
            chk_b("fetch_valid", bus.fetch_valid, exp_valid);
            if (exp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_data: got %0h, expected no read pending", bus.fetch_data);
                end else begin
                    chk_w("fetch_data", bus.fetch_data, sb_q.pop_front());
                end
            end
            if (bus.load_valid && bus.load_ready) model[bus.load_addr] = bus.load_data;
            exp_valid = bus.fetch_gnt;
            if (bus.fetch_gnt) sb_q.push_back(model[bus.fetch_addr]);
        end
    end

    function automatic vec_t mk(input logic fr, input logic [AW-1:0] fa, input logic lv,
                                input logic [AW-1:0] la, input logic [DW-1:0] ld, input logic ll,
                                input logic rb, input logic eg, input logic er, input logic eb,
                                input logic ew, input logic [AW-1:0] ea);
        vec_t v;
        v.fr = fr; v.fa = fa; v.lv = lv; v.la = la; v.ld = ld; v.ll = ll; v.rb = rb;
        v.eg = eg; v.er = er; v.eb = eb; v.ew = ew; v.ea = ea;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.fetch_req  = v.fr;
        bus.fetch_addr = v.fa;
        bus.load_valid = v.lv;
        bus.load_addr  = v.la;
        bus.load_data  = v.ld;
        bus.load_last  = v.ll;
        bus.reboot     = v.rb;
    endtask

    // Drive one cycle (called at posedge+1), check at negedge, return at posedge+1
    task automatic step(input vec_t v, input string tag);
        drive(v);
        @(negedge clock);
        chk_b($sformatf("%s fetch_gnt", tag), bus.fetch_gnt, v.eg);
        chk_b($sformatf("%s load_ready", tag), bus.load_ready, v.er);
        chk_b($sformatf("%s boot_done", tag), bus.boot_done, v.eb);
        chk_b($sformatf("%s mem_we", tag), bus.mem_we, v.ew);
        chk_w($sformatf("%s mem_addr", tag), DW'(bus.mem_addr), DW'(v.ea));
        if (v.ew) chk_w($sformatf("%s mem_wdata", tag), bus.mem_wdata, v.ld);
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t tbl [$];

        drive(mk(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0));
        #12;
        chk_b("rst fetch_gnt", bus.fetch_gnt, 1'b0);
        chk_b("rst fetch_valid", bus.fetch_valid, 1'b0);
        chk_b("rst boot_done", bus.boot_done, 1'b0);
        chk_b("rst load_ready", bus.load_ready, 1'b1);
        chk_b("rst mem_we", bus.mem_we, 1'b0);
        chk_w("rst mem_addr", DW'(bus.mem_addr), 32'h0);
        chk_w("rst mem_wdata", bus.mem_wdata, 32'h0);
        #10 reset_n = 1'b1;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        // Boot: three words, last on word 2; fetch held high and refused in BOOT
        tbl.push_back(mk(1'b1, 10'd0, 1'b0, 10'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0));
        tbl.push_back(mk(1'b1, 10'd0, 1'b1, 10'd0, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0));
        tbl.push_back(mk(1'b1, 10'd2, 1'b1, 10'd1, 32'h1111_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd1));
        tbl.push_back(mk(1'b1, 10'd2, 1'b1, 10'd2, 32'h1111_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd2));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1'b1, AW'(k), 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(k)));
        tbl.push_back(mk(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd2));
        // RUN patch writes 3..7 (load_last on 5 must be ignored)
        for (int k = 3; k < 8; k++)
            tbl.push_back(mk(1'b0, 10'd0, 1'b1, AW'(k), 32'hC0DE_0000 | DW'(k), (k == 5), 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b1, AW'(k)));
        // Back-to-back fetches 0..7
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, AW'(k), 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(k)));
        // Starvation: 4 refused cycles, then one forced load
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b1, 10'd0, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0));
        tbl.push_back(mk(1'b1, 10'd0, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd5));
        tbl.push_back(mk(1'b1, 10'd5, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd5));
        tbl.push_back(mk(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd5));
        // Counter clears when load_valid drops: 2 refusals, gap, then full 4 again
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(1'b1, 10'd1, 1'b1, 10'd6, 32'h6666_0006, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1));
        tbl.push_back(mk(1'b1, 10'd1, 1'b0, 10'd6, 32'h6666_0006, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b1, 10'd1, 1'b1, 10'd6, 32'h6666_0006, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1));
        tbl.push_back(mk(1'b1, 10'd1, 1'b1, 10'd6, 32'h6666_0006, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd6));
        tbl.push_back(mk(1'b1, 10'd6, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd6));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // reboot together with a granted fetch: read still completes
        step(mk(1'b1, 10'd5, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd5), "rbt_n");
        chk_b("rbt_n1 fetch_valid", bus.fetch_valid, 1'b1);
        chk_b("rbt_n1 boot_done", bus.boot_done, 1'b0);
        for (int k = 0; k < 3; k++)
            step(mk(1'b1, 10'd6, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd5),
                 $sformatf("rbt_hold%0d", k));
        step(mk(1'b1, 10'd6, 1'b1, 10'd8, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd8), "rbt_last");
        step(mk(1'b1, 10'd8, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd8), "rbt_fetch");

        // reboot + load_last in BOOT: reboot wins, stays in BOOT
        step(mk(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd8), "cf_rbt");
        step(mk(1'b0, 10'd0, 1'b1, 10'd9, 32'h9999_0009, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd9), "cf_both");
        for (int k = 0; k < 2; k++)
            step(mk(1'b1, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd9),
                 $sformatf("cf_stay%0d", k));
        step(mk(1'b0, 10'd0, 1'b1, 10'd9, 32'h9999_0009, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd9), "cf_last");
        step(mk(1'b1, 10'd9, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd9), "cf_fetch");

        // Async reset between edges with a read in flight
        step(mk(1'b1, 10'd3, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd3), "ar_pre");
        chk_b("ar_pre fetch_valid", bus.fetch_valid, 1'b1);
        mon_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk_b("ar fetch_valid", bus.fetch_valid, 1'b0);
        chk_b("ar boot_done", bus.boot_done, 1'b0);
        chk_b("ar fetch_gnt", bus.fetch_gnt, 1'b0);
        chk_b("ar load_ready", bus.load_ready, 1'b1);
        chk_b("ar mem_we", bus.mem_we, 1'b0);
        chk_w("ar mem_addr", DW'(bus.mem_addr), 32'h0);
        chk_w("ar mem_wdata", bus.mem_wdata, 32'h0);
        sb_q.delete();
        exp_valid = 1'b0;
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        // Boot sequence repeats with fresh data
        for (int k = 0; k < 3; k++)
            step(mk(1'b1, 10'd0, 1'b1, AW'(k), 32'hB00B_0000 | DW'(k), (k == 2), 1'b0,
                    1'b0, 1'b1, 1'b0, 1'b1, AW'(k)), $sformatf("rb_load%0d", k));
        for (int k = 0; k < 3; k++)
            step(mk(1'b1, AW'(k), 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(k)),
                 $sformatf("rb_fetch%0d", k));
        step(mk(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd2), "rb_idle");

        chk_w("sb_drain", DW'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencer and arbiter for the single-port instruction RAM. It shares the RAM between the CPU fetch path and the program loader. After reset it holds the CPU off until the loader has written a complete program. It then serves CPU fetches with priority and still lets late loader writes through under a starvation bound. It sits between the fetch stage, the loader and the instruction RAM, which has a 1-cycle synchronous read.

## Interface
Parameters:
- ADDR_W, 10, instruction RAM address width (1024 words).
- DATA_W, 32, instruction word width.
- STARVE_MAX, 4, consecutive RUN cycles a pending loader write may be refused before it is forced through; legal 1..15.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  CPU requests the word at fetch_addr.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_gnt  out  1  request accepted this cycle.
- fetch_valid  out  1  fetch_data valid; 1 cycle after fetch_gnt.
- fetch_data  out  DATA_W  fetched instruction word.
- load_valid  in  1  loader offers a write.
- load_addr  in  ADDR_W  write address.
- load_data  in  DATA_W  write data.
- load_last  in  1  final word of the boot image; qualified by load_valid.
- load_ready  out  1  write accepted this cycle.
- reboot  in  1  single-cycle pulse; return to BOOT.
- boot_done  out  1  high in RUN.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address.

## Operation
- FSM states are BOOT and RUN. Reset enters BOOT.
- **BOOT:**
  - fetch_gnt = 0.
  - load_ready = 1.
  - A write occurs on every cycle with load_valid.
  - A write with load_last = 1 moves the FSM to RUN on the next cycle.
- **RUN, arbitration per cycle:**
  - If fetch_req=1 and starve_cnt < STARVE_MAX, grant the fetch.
  - Otherwise, if load_valid=1, grant the load.
  - Otherwise the port is idle.
- **starve_cnt (4 bits):**
  - Increments when load_valid=1 and the load is refused.
  - Clears on a load grant, and whenever load_valid=0.
  - Saturates at STARVE_MAX.
- **Forced load:** at starve_cnt == STARVE_MAX the load wins one cycle. fetch_gnt = 0 that cycle and the CPU must hold fetch_req/fetch_addr.
- Loader writes in RUN are legal (self-modifying / patch). load_last is ignored in RUN.
- **reboot:**
  - If a read is in flight (fetch granted the previous cycle), fetch_valid/fetch_data for it are still delivered.
  - The FSM enters BOOT on the cycle after the pulse.
  - fetch_gnt = 0 from that cycle onward.
  - reboot while already in BOOT has no effect.
- **Mem port muxing** is combinational from the current grant:
  - Load grant: mem_addr = load_addr, mem_we = 1, mem_wdata = load_data.
  - Fetch grant: mem_addr = fetch_addr, mem_we = 0.
  - Idle: mem_addr holds its previous registered value, mem_we = 0.
- fetch_data = mem_rdata, passed through unregistered.

## Timing
- Reset values:
  - state = BOOT.
  - boot_done = 0, fetch_gnt = 0, fetch_valid = 0.
  - load_ready = 1 (comb; BOOT).
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - starve_cnt = 0.
- **Fetch latency:** grant at cycle N gives fetch_valid = 1 at N+1. Back-to-back fetches give a throughput of 1 word/cycle.
- **Load:** the write commits at the rising edge ending the granted cycle. A fetch of the same address granted at N+1 returns the new data.
- fetch_gnt and load_ready are never both 1 in one cycle.
- **BOOT to RUN:** the last write is at cycle N. boot_done rises at N+1, and the first possible fetch_gnt is at N+1.
- **Reset mid-operation:** asynchronous clear.
  - Any in-flight fetch_valid is dropped.
  - A write in progress at the edge is undefined for that word.
  - The loader must restart.
- **Simultaneous events:**
  - reboot in the same cycle as load_last in BOOT: reboot wins and the FSM stays in BOOT.
  - reboot in RUN in the same cycle as a fetch_req: the fetch is still granted that cycle.
- mem_addr wraps naturally at 2^ADDR_W, with no range checking.

## Structure
- The shared package holds:
  - state encoding (ST_BOOT = 1'b0, ST_RUN = 1'b1);
  - default ADDR_W / DATA_W;
  - starve counter width.
  The instruction memory and fetch stage reuse these.
- Single module, no sub-modules. The starve counter is a plain register.
- The instruction RAM is external, so this block is reusable with any 1-cycle sync RAM.

## Test plan
- **Reset + boot:** load 3 words, with load_last on word 2.
  - fetch_gnt = 0 throughout BOOT.
  - boot_done rises 1 cycle after the last write.
  - Fetch addresses 0..2 return the written words with 1-cycle latency.
- **Back-to-back fetch:** in RUN, fetch_req held for 8 cycles, addresses 0..7 → fetch_valid high for 8 consecutive cycles, data in order.
- **Starvation, STARVE_MAX=4:** continuous fetch_req plus load_valid at address 5 with data 32'hDEADBEEF.
  - Exactly 4 refused cycles, then load_ready = 1 and fetch_gnt = 0 for 1 cycle.
  - A subsequent fetch of address 5 returns DEADBEEF.
- **reboot during fetch:** fetch granted at N, reboot at N.
  - fetch_valid delivered at N+1.
  - boot_done = 0 at N+1.
  - fetch_gnt stays 0 until a new load_last.
- **Same-cycle conflict:** reboot together with load_last in BOOT → remains in BOOT and boot_done stays 0.
- **Async reset mid-RUN:** assert reset_n low between edges → all outputs reach their reset values immediately. The boot sequence then repeats correctly.
